sdram_port_arbiter: RTL and testbench

- Shares the single command interface of sdram_controller between NREQ requesters: port 0 is video and has high priority; ports 1..NREQ-1 (CPU, DMA, ...) are served round-robin.
- Issues one transaction at a time and waits for its completion, then routes read data and a completion pulse back to the owning port.
- Sits between the system bus masters and sdram_controller in the clk_sys domain.

---
 rtl/sdram_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the sdram_controller command port between NREQ
// requesters. Port 0 (video) has priority, bounded by HI_MAX back-to-back
// grants while a low port waits; ports 1..NREQ-1 are served round-robin.
// One transaction is outstanding at a time.
module sdram_port_arbiter #(
  parameter int NREQ   = 3,
  parameter int AW     = 22,
  parameter int DW     = 16,
  parameter int BEW    = DW/8,
  parameter int HI_MAX = 4
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic                init_done,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     we,
  input  logic [NREQ*AW-1:0]  addr,
  input  logic [NREQ*DW-1:0]  wdata,
  input  logic [NREQ*BEW-1:0] be,
  output logic [NREQ-1:0]     ack,
  output logic [NREQ-1:0]     done,
  output logic [DW-1:0]       rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic [BEW-1:0]      mem_be,
  input  logic                mem_ready,
  input  logic                mem_done,
  input  logic [DW-1:0]       mem_rdata
);

  localparam int PW = $clog2(NREQ);
  localparam int IW = PW + 1;
  localparam int HW = $clog2(HI_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]   hi_cnt_q, hi_cnt_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BEW-1:0]  mem_be_q, mem_be_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            any_low, p0_win, grant, rr_found;
  logic [PW-1:0]   rr_win, win, rr_next, idx_p;
  logic [IW-1:0]   idx;

  assign any_low = |req[NREQ-1:1];
  assign p0_win  = req[0] && (!any_low || (hi_cnt_q < HW'(HI_MAX)));
  assign win     = p0_win ? '0 : rr_win;
  assign grant   = (state_q == S_IDLE) && init_done && (|req);
  assign rr_next = (win == PW'(NREQ-1)) ? PW'(1) : win + PW'(1);

  // Round-robin search over low ports, starting at rr_ptr and wrapping inside 1..NREQ-1
  always_comb begin
    rr_win   = rr_ptr_q;
    rr_found = 1'b0;
    idx      = '0;
    idx_p    = '0;
    for (int i = 0; i < NREQ-1; i++) begin
      idx = IW'(rr_ptr_q) + IW'(i);
      if (idx >= IW'(NREQ)) idx = idx - IW'(NREQ-1);
      idx_p = idx[PW-1:0];
      if (!rr_found && req[idx_p]) begin
        rr_found = 1'b1;
        rr_win   = idx_p;
      end
    end
  end

  // State register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: grant -> issue until accepted -> wait for completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant)     state_d = S_ISSUE;
      S_ISSUE: if (mem_ready) state_d = S_WAIT;
      S_WAIT:  if (mem_done)  state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Output: ack is combinational so it coincides with the accept cycle
  always_comb begin
    ack = '0;
    if (state_q == S_ISSUE && mem_ready) ack[owner_q] = 1'b1;
  end

  // Datapath: latch winner's command, fairness counters, completion routing
  always_comb begin
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    hi_cnt_d    = hi_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    rdata_d     = rdata_q;
    done_d      = '0;
    if (grant) begin
      owner_d     = win;
      mem_req_d   = 1'b1;
      mem_we_d    = we[win];
      mem_addr_d  = addr[win*AW +: AW];
      mem_wdata_d = wdata[win*DW +: DW];
      mem_be_d    = be[win*BEW +: BEW];
      if (p0_win) begin
        if (!any_low)                        hi_cnt_d = '0;
        else if (hi_cnt_q != HW'(HI_MAX))    hi_cnt_d = hi_cnt_q + HW'(1);
      end else begin
        hi_cnt_d = '0;
        rr_ptr_d = rr_next;
      end
    end else if (!any_low) begin
      hi_cnt_d = '0;
    end
    if (state_q == S_ISSUE && mem_ready) mem_req_d = 1'b0;
    if (state_q == S_WAIT && mem_done) begin
      rdata_d         = mem_rdata;
      done_d[owner_q] = 1'b1;
    end
  end

  // Registers; reset drops mem_req at once and forgets the owner
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= '0;
      rr_ptr_q    <= PW'(1);
      hi_cnt_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
    end else begin
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      hi_cnt_q    <= hi_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
    end
  end

  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: table of scenarios (request counts, controller
// timing, expected grant order) driven through a requester/controller model,
// with a command queue and a completion queue as scoreboard, plus a hand
// sequence for reset in the middle of a transaction.
module tb_sdram_port_arbiter;
  localparam int NREQ = 3, AW = 22, DW = 16, BEW = 2, HI_MAX = 4;

  logic                clk_sys = 1'b0;
  logic                rst_n, init_done;
  logic [NREQ-1:0]     req, we, ack, done;
  logic [NREQ*AW-1:0]  addr;
  logic [NREQ*DW-1:0]  wdata;
  logic [NREQ*BEW-1:0] be;
  logic [DW-1:0]       rdata, mem_wdata, mem_rdata;
  logic                mem_req, mem_we, mem_ready, mem_done;
  logic [AW-1:0]       mem_addr;
  logic [BEW-1:0]      mem_be;

  sdram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .BEW(BEW), .HI_MAX(HI_MAX)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .init_done(init_done),
    .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack), .done(done), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct { int n0, n1, n2, init_dly, rd_dly, lat; string order; } vec_t;
  typedef struct { int port; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [BEW-1:0] be; } cmd_t;
  typedef struct { int port; logic [DW-1:0] data; } cpl_t;

  cmd_t exp_q[$];
  cpl_t cpl_q[$];
  int   nchecks = 0, nerr = 0;
  int   cnt[NREQ], pidx[NREQ];
  vec_t vecs[7];

  function automatic logic [AW-1:0] addr_of(int i, int j);
    logic [AW-1:0] a;
    a = 22'h000123 + AW'(j * 16);
    if (i != 1) a = a + (AW'(i) << 18);
    return a;
  endfunction

  function automatic cmd_t mk_cmd(int i, int j);
    cmd_t c;
    c.port  = i;
    c.we    = ((i + j) % 2 == 0);
    c.addr  = addr_of(i, j);
    c.wdata = 16'hC000 + DW'(i * 256 + j);
    c.be    = (j % 3 == 1) ? 2'b01 : 2'b11;
    return c;
  endfunction

  // Controller read data as a pure function of address
  function automatic logic [DW-1:0] rd_fn(logic [AW-1:0] a);
    return (a == 22'h000123) ? 16'hBEEF : (a[15:0] ^ 16'h5A3C);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drive_ports();
    cmd_t c;
    for (int i = 0; i < NREQ; i++) begin
      c = mk_cmd(i, pidx[i]);
      req[i]               = (cnt[i] > 0);
      we[i]                = c.we;
      addr[i*AW +: AW]     = c.addr;
      wdata[i*DW +: DW]    = c.wdata;
      be[i*BEW +: BEW]     = c.be;
    end
  endtask

  task automatic run_vec(vec_t v, bit do_reset);
    int pj[NREQ];
    int cyc, dcnt, rdy_cnt, p;
    bit busy, wb;
    logic [DW-1:0] bdata;
    logic [NREQ-1:0] exp_ack;
    cmd_t h;
    cpl_t cp;
    mem_ready = 1'b0; mem_done = 1'b0; req = '0; init_done = 1'b0;
    if (do_reset) begin
      rst_n = 1'b0;
      step();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_ack", ack, 0);
      chk("rst_done", done, 0);
      chk("rst_rdata", rdata, 0);
      rst_n = 1'b1;
    end
    cnt[0] = v.n0; cnt[1] = v.n1; cnt[2] = v.n2;
    for (int i = 0; i < NREQ; i++) begin pidx[i] = 0; pj[i] = 0; end
    for (int k = 0; k < v.order.len(); k++) begin
      p = int'(v.order[k]) - 48;
      exp_q.push_back(mk_cmd(p, pj[p]));
      pj[p]++;
    end
    init_done = (v.init_dly == 0);
    busy = 1'b0; cyc = 0; dcnt = 0; rdy_cnt = 0; bdata = '0;
    drive_ports();
    while (exp_q.size() > 0 || cpl_q.size() > 0 || busy) begin
      step();
      cyc++;
      if (cyc > 400) begin
        nchecks++; nerr++;
        $display("FAIL timeout: %0d commands and %0d completions still pending", exp_q.size(), cpl_q.size());
        exp_q.delete(); cpl_q.delete();
        break;
      end
      if (cyc >= v.init_dly) init_done = 1'b1;
      if (cyc <= v.init_dly) chk("hold_off_mem_req", mem_req, 0);
      if (cyc == v.init_dly + 1) chk("grant_latency", mem_req, 1);
      chk("done_onehot", $onehot0(done), 1);
      if (done != 0) begin
        chk("gap_after_done", mem_req, 0);
        if (cpl_q.size() == 0) begin
          nchecks++; nerr++;
          $display("FAIL unexpected_done: got %0b expected none", done);
        end else begin
          cp = cpl_q.pop_front();
          chk("done_port", done, NREQ'(1) << cp.port);
          chk("rdata", rdata, cp.data);
        end
      end
      // controller model
      wb = busy;
      mem_done = 1'b0;
      if (busy) begin
        chk("mem_req_in_wait", mem_req, 0);
        if (dcnt <= 1) begin mem_done = 1'b1; mem_rdata = bdata; busy = 1'b0; end
        else dcnt--;
      end
      mem_ready = 1'b0;
      if (mem_req && !wb) begin
        mem_ready = (rdy_cnt >= v.rd_dly);
        rdy_cnt++;
      end else rdy_cnt = 0;
      #1;
      exp_ack = '0;
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          nchecks++; nerr++;
          $display("FAIL unexpected_cmd: addr %0h with nothing expected", mem_addr);
        end else begin
          h = exp_q[0];
          chk("cmd", {mem_we, mem_addr, mem_be, mem_we ? mem_wdata : 16'h0},
                     {h.we, h.addr, h.be, h.we ? h.wdata : 16'h0});
          if (mem_ready) exp_ack = NREQ'(1) << h.port;
        end
      end
      chk("ack", ack, exp_ack);
      if (exp_ack != 0) begin
        void'(exp_q.pop_front());
        cp.port = h.port; cp.data = rd_fn(h.addr);
        cpl_q.push_back(cp);
        busy = 1'b1; dcnt = v.lat; bdata = rd_fn(h.addr);
        rdy_cnt = 0;
      end
      for (int i = 0; i < NREQ; i++)
        if (ack[i] && cnt[i] > 0) begin pidx[i]++; cnt[i]--; end
      drive_ports();
    end
    mem_done = 1'b0; mem_ready = 1'b0; req = '0;
  endtask

  initial begin
    vec_t tail;
    rst_n = 1'b0; init_done = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    for (int i = 0; i < NREQ; i++) begin cnt[i] = 0; pidx[i] = 0; end
    //          n0 n1 n2 init rd lat order
    vecs[0] = '{0, 1, 0, 0, 0, 3, "1"};
    vecs[1] = '{0, 3, 3, 0, 0, 2, "121212"};
    vecs[2] = '{8, 2, 0, 0, 0, 1, "0000100001"};
    vecs[3] = '{2, 2, 2, 0, 1, 2, "001212"};
    vecs[4] = '{0, 0, 1, 0, 5, 1, "2"};
    vecs[5] = '{1, 1, 1, 5, 0, 2, "012"};
    vecs[6] = '{0, 2, 1, 0, 0, 1, "121"};
    for (int v = 0; v < 7; v++) run_vec(vecs[v], 1'b1);

    // reset while waiting for completion
    rst_n = 1'b0; init_done = 1'b1;
    for (int i = 0; i < NREQ; i++) begin cnt[i] = 0; pidx[i] = 0; end
    drive_ports();
    step();
    rst_n = 1'b1;
    cnt[1] = 1; drive_ports();
    step();
    chk("rw_mem_req_up", mem_req, 1);
    mem_ready = 1'b1; #1;
    chk("rw_ack", ack, 3'b010);
    cnt[1] = 0; drive_ports();
    step();
    mem_ready = 1'b0;
    chk("rw_wait_mem_req", mem_req, 0);
    step();
    rst_n = 1'b0; #1;
    chk("rw_rst_mem_req", mem_req, 0);
    chk("rw_rst_ack", ack, 0);
    chk("rw_rst_done", done, 0);
    step();
    rst_n = 1'b1; mem_done = 1'b1; mem_rdata = 16'h1234;
    step();
    mem_done = 1'b0;
    chk("rw_late_done", done, 0);
    step();
    chk("rw_late_done2", done, 0);
    chk("rw_rdata_kept", rdata, 0);
    tail = '{0, 0, 1, 0, 0, 2, "2"};
    run_vec(tail, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
